// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and constants for the serial subtractor
//
// Purpose : sequencer state encoding and the carry preset value.
// Ports   : none (package).
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // A - B is computed as A + ~B + 1, so the carry starts at 1.
   localparam logic CARRY_INIT = 1'b1;

endpackage

// File: rtl/serial_sub_cell.sv
// rtl/serial_sub_cell.sv - 1-bit serial subtract cell with carry flop
//
// Purpose : full adder on (a, ~b, carry) with its carry flop.
// Ports   : clock, reset_b    - clock, async active-low reset
//           shift_en          - advance the carry by one bit
//           preset            - reload the carry with CARRY_INIT
//           a_bit, b_bit      - current operand LSBs
//           diff_bit          - difference bit for this position
//           carry_next        - carry that will be stored on this edge
module serial_sub_cell (
   input  logic clock,
   input  logic reset_b,
   input  logic shift_en,
   input  logic preset,
   input  logic a_bit,
   input  logic b_bit,
   output logic diff_bit,
   output logic carry_next
);
   import serial_sub_pkg::*;

   logic b_inv;
   logic carry_q;
   logic carry_d;

   assign b_inv      = ~b_bit;
   assign diff_bit   = a_bit ^ b_inv ^ carry_q;
   assign carry_next = (a_bit & b_inv) | (a_bit & carry_q) | (b_inv & carry_q);

   always_comb begin
      carry_d = carry_q;
      if (preset) begin
         carry_d = CARRY_INIT;
      end else if (shift_en) begin
         carry_d = carry_next;
      end
   end

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         carry_q <= CARRY_INIT;
      end else begin
         carry_q <= carry_d;
      end
   end

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - sequencer for a bit-serial two's-complement subtractor
//
// Purpose : accepts (A, B), shifts WIDTH bits LSB-first through serial_sub_cell,
//           then presents A - B, unsigned borrow and magnitude.
// Option  : SERIAL_SUB_OVF_EN builds the signed overflow flag; otherwise 0.
// Ports   : clock, reset_b     - clock, async active-low reset
//           start_i, a_i, b_i  - request and operands (sampled in IDLE)
//           busy_o             - accept cycle through done cycle
//           shift_en_o         - high for exactly WIDTH cycles per operation
//           done_o             - one-cycle result strobe
//           diff_o, negative_o, magnitude_o, overflow_o - held results
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_b,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             shift_en_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             negative_o,
   output logic [WIDTH-1:0] magnitude_o,
   output logic             overflow_o
);
   import serial_sub_pkg::*;

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               busy_q, busy_d;
   logic               shift_en_q, shift_en_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   mag_q, mag_d;

   logic               accept;
   logic               last_shift;
   logic               diff_bit;
   logic               carry_next;
   logic [WIDTH-1:0]   res_next;

   assign accept     = (state_q == IDLE) && start_i;
   assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));
   // Result fills from the MSB end so after WIDTH shifts bit 0 is the LSB.
   assign res_next   = {diff_bit, res_q[WIDTH-1:1]};

   serial_sub_cell u_cell (
      .clock      (clock),
      .reset_b    (reset_b),
      .shift_en   (shift_en_q),
      .preset     (accept),
      .a_bit      (a_q[0]),
      .b_bit      (b_q[0]),
      .diff_bit   (diff_bit),
      .carry_next (carry_next)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      res_d      = res_q;
      busy_d     = busy_q;
      shift_en_d = shift_en_q;
      done_d     = 1'b0;
      diff_d     = diff_q;
      neg_d      = neg_q;
      mag_d      = mag_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               a_d        = a_i;
               b_d        = b_i;
               res_d      = '0;
               cnt_d      = '0;
               busy_d     = 1'b1;
               shift_en_d = 1'b1;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = res_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_shift) begin
               // Results are loaded on the final shift edge so they are
               // valid in the same cycle as done_o.
               shift_en_d = 1'b0;
               done_d     = 1'b1;
               diff_d     = res_next;
               neg_d      = ~carry_next;
               mag_d      = carry_next ? res_next : (~res_next + WIDTH'(1));
               state_d    = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         res_q      <= '0;
         busy_q     <= 1'b0;
         shift_en_q <= 1'b0;
         done_q     <= 1'b0;
         diff_q     <= '0;
         neg_q      <= 1'b0;
         mag_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         res_q      <= res_d;
         busy_q     <= busy_d;
         shift_en_q <= shift_en_d;
         done_q     <= done_d;
         diff_q     <= diff_d;
         neg_q      <= neg_d;
         mag_q      <= mag_d;
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   // Operand MSBs are shifted out of a_q/b_q, so keep a copy for the flag.
   logic a_msb_q, a_msb_d;
   logic b_msb_q, b_msb_d;
   logic ovf_q, ovf_d;

   always_comb begin
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      ovf_d   = ovf_q;
      if (accept) begin
         a_msb_d = a_i[WIDTH-1];
         b_msb_d = b_i[WIDTH-1];
      end
      if (last_shift) begin
         ovf_d = (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
      end
   end

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         ovf_q   <= ovf_d;
      end
   end

   assign overflow_o = ovf_q;
`else
   assign overflow_o = 1'b0;
`endif

   assign busy_o      = busy_q;
   assign shift_en_o  = shift_en_q;
   assign done_o      = done_q;
   assign diff_o      = diff_q;
   assign negative_o  = neg_q;
   assign magnitude_o = mag_q;

endmodule
